imm_decode_stage: RTL and testbench
===================================

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- XLEN, 32, immediate output width; legal values are 32 and 64.
- TAG_W, 32, width of the opaque sideband tag (for example the PC).
- CNT_W, 16, width of the illegal-instruction counter.

REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk, in, 1, the single clock.
- rst, in, 1, synchronous active-high reset.
- flush, in, 1, discard all held entries.
- in_valid, in, 1, an input beat is offered.
- in_ready, out, 1, the block can accept a beat.
- in_inst, in, 32, raw instruction.
- in_tag, in, TAG_W, sideband tag.
- out_valid, out, 1, an output beat is present.
- out_ready, in, 1, the consumer accepts the beat.
- out_imm, out, XLEN, sign-extended immediate.
- out_fmt, out, 3, format code.
- out_illegal, out, 1, opcode not recognised.
- out_tag, out, TAG_W, tag of the beat.
- illegal_cnt, out, CNT_W, saturating count of illegal instructions accepted.

Function
REQ-003 out_fmt SHALL use these codes: R=0, I=1, S=2, B=3, U=4, J=5, INVALID=7.

REQ-004 The format SHALL be derived from in_inst[6:0] as follows:
- U: 0110111 (LUI), 0010111 (AUIPC).
- J: 1101111.
- I: 1100111, 0000011, 0010011, 0001111, 1110011.
- B: 1100011.
- S: 0100011.
- R: 0110011.
- INVALID: any other value.

REQ-005 Immediate bit selection SHALL be:
- I: inst[31:20].
- S: {inst[31:25], inst[11:7]}.
- B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U: {inst[31:12], 12'b0}.
- J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.

REQ-006 The selected immediate SHALL be sign-extended from inst[31] to XLEN bits for all formats, including U.

REQ-007 R and INVALID formats SHALL produce out_imm = 0.

REQ-008 out_illegal SHALL be 1 when and only when out_fmt = INVALID.

REQ-009 The block SHALL be a two-entry elastic stage with latency 1 cycle. The entries are a main output register and a skid register.

REQ-010 A beat SHALL be accepted in a cycle where in_valid and in_ready are both 1.

REQ-011 A beat SHALL be consumed in a cycle where out_valid and out_ready are both 1.

REQ-012 in_ready SHALL be registered and SHALL equal NOT skid_valid. It SHALL never depend combinationally on out_ready.

REQ-013 Routing of an accepted beat SHALL be:
- Main register empty, or main consumed in the same cycle with the skid empty: the beat loads the main register.
- Otherwise: the beat loads the skid register.

REQ-014 When the main register is consumed and the skid register is valid, the skid contents SHALL move to the main register in the same edge.

REQ-015 A simultaneous accept and consume SHALL lose no beat and duplicate no beat.

REQ-016 Beats SHALL leave in acceptance order.

REQ-017 out_valid SHALL equal main_valid. The output fields SHALL come directly from registers, with no combinational path from in_* to out_*.

REQ-018 out_* data SHALL remain stable while out_valid = 1 and out_ready = 0.

REQ-019 flush = 1 SHALL clear main_valid and skid_valid at the next edge and SHALL set in_ready = 1. A beat offered in the flush cycle SHALL be dropped.

REQ-020 illegal_cnt SHALL increment by 1 for each accepted beat whose format is INVALID. It SHALL saturate at 2^CNT_W-1. Flush SHALL NOT clear it.

REQ-021 A beat dropped by flush SHALL NOT increment illegal_cnt.

Reset
REQ-022 While rst = 1 at a clock edge, the block SHALL reset as follows:
- main_valid = 0, skid_valid = 0, out_valid = 0.
- in_ready = 1.
- out_imm = 0, out_fmt = 7, out_illegal = 0, out_tag = 0.
- illegal_cnt = 0.

REQ-023 rst SHALL take priority over flush and over all handshakes. A reset in the middle of a transfer SHALL discard every held beat.

REQ-024 The first beat SHALL be acceptable in the first cycle after rst deasserts.

Verification
REQ-025 Directed scenario: 0xFFF00093 with XLEN=32 -> next cycle out_fmt=1, out_imm=0xFFFFFFFF, out_illegal=0.

REQ-026 Directed scenario: 0x123452B7 (LUI) -> out_imm=0x12345000, fmt=4. With XLEN=64, 0x800002B7 -> out_imm=0xFFFFFFFF80000000.

REQ-027 Directed scenario: 0xFE000EE3 (beq, -4) -> out_fmt=3, out_imm=0xFFFFFFFC. Raw instruction 0x0000007F -> fmt=7, imm=0, illegal=1, illegal_cnt +1.

REQ-028 Directed scenario: out_ready held 0, with tags 1, 2, 3 offered back to back:
- Tags 1 and 2 are accepted.
- in_ready=0 from the cycle after tag 2 is accepted.
- Releasing out_ready yields 1, 2, 3 in order with no gaps once the pipe is full.

REQ-029 Directed scenario: both entries full, then flush=1 for one cycle with in_valid=1 and an illegal instruction offered -> next cycle out_valid=0, in_ready=1, illegal_cnt unchanged.

REQ-030 Directed scenario: CNT_W=2, five illegal beats accepted -> illegal_cnt reads 3 and holds. Then rst=1 with both entries full -> all valids 0 and illegal_cnt=0 on the next cycle.

Source files
------------

// File: rtl/imm_decode_stage.sv
// RISC-V immediate decode stage: classifies the opcode, extracts and sign-extends the
// immediate, and passes beats through a two-entry (main + skid) elastic buffer.
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_INV = 3'd7;

    logic [2:0]         dec_fmt;
    logic signed [31:0] dec_imm32;
    logic [XLEN-1:0]    dec_imm;
    logic               dec_illegal;

    logic               main_valid;
    logic               skid_valid;
    logic [XLEN-1:0]    skid_imm;
    logic [2:0]         skid_fmt;
    logic               skid_illegal;
    logic [TAG_W-1:0]   skid_tag;

    logic               accept;
    logic               consume;
    logic               main_valid_n;
    logic               skid_valid_n;
    logic               main_from_in;
    logic               main_from_skid;
    logic               skid_from_in;

    always_comb begin
        dec_fmt = FMT_INV;
        case (in_inst[6:0])
            7'b0110111, 7'b0010111: dec_fmt = FMT_U;
            7'b1101111:             dec_fmt = FMT_J;
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0001111, 7'b1110011: dec_fmt = FMT_I;
            7'b1100011:             dec_fmt = FMT_B;
            7'b0100011:             dec_fmt = FMT_S;
            7'b0110011:             dec_fmt = FMT_R;
            default:                dec_fmt = FMT_INV;
        endcase
    end

    // Every format's 32-bit immediate already carries inst[31] in bit 31, so
    // widening to XLEN is a plain signed extension (U included).
    always_comb begin
        dec_imm32 = '0;
        case (dec_fmt)
            FMT_I: dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            FMT_S: dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            FMT_B: dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                in_inst[30:25], in_inst[11:8], 1'b0};
            FMT_U: dec_imm32 = {in_inst[31:12], 12'b0};
            FMT_J: dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                in_inst[20], in_inst[30:21], 1'b0};
            default: dec_imm32 = '0;
        endcase
    end

    assign dec_imm     = XLEN'(dec_imm32);
    assign dec_illegal = (dec_fmt == FMT_INV);

    assign accept    = in_valid & in_ready & ~flush;
    assign consume   = main_valid & out_ready;
    assign out_valid = main_valid;

    always_comb begin
        main_valid_n   = main_valid;
        skid_valid_n   = skid_valid;
        main_from_in   = 1'b0;
        main_from_skid = 1'b0;
        skid_from_in   = 1'b0;
        if (consume) begin
            if (skid_valid) begin
                main_from_skid = 1'b1;
                main_valid_n   = 1'b1;
                skid_valid_n   = 1'b0;
                if (accept) begin
                    skid_from_in = 1'b1;
                    skid_valid_n = 1'b1;
                end
            end else begin
                main_from_in = accept;
                main_valid_n = accept;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_from_in = 1'b1;
                main_valid_n = 1'b1;
            end else begin
                skid_from_in = 1'b1;
                skid_valid_n = 1'b1;
            end
        end
    end

    // The main register doubles as the output register; data regs keep their
    // contents on flush since only the valids matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid   <= 1'b0;
            skid_valid   <= 1'b0;
            in_ready     <= 1'b1;
            out_imm      <= '0;
            out_fmt      <= FMT_INV;
            out_illegal  <= 1'b0;
            out_tag      <= '0;
            skid_imm     <= '0;
            skid_fmt     <= FMT_INV;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
            in_ready   <= ~skid_valid_n;
            if (main_from_skid) begin
                out_imm     <= skid_imm;
                out_fmt     <= skid_fmt;
                out_illegal <= skid_illegal;
                out_tag     <= skid_tag;
            end else if (main_from_in) begin
                out_imm     <= dec_imm;
                out_fmt     <= dec_fmt;
                out_illegal <= dec_illegal;
                out_tag     <= in_tag;
            end
            if (skid_from_in) begin
                skid_imm     <= dec_imm;
                skid_fmt     <= dec_fmt;
                skid_illegal <= dec_illegal;
                skid_tag     <= in_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (accept && dec_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: a 32-bit/16-bit-counter instance and a
// 64-bit/2-bit-counter instance share one stimulus stream and one expected queue.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_tag;

    logic        in_ready_a, out_valid_a, out_illegal_a;
    logic [31:0] out_imm_a, out_tag_a;
    logic [2:0]  out_fmt_a;
    logic [15:0] cnt_a;

    logic        in_ready_b, out_valid_b, out_illegal_b;
    logic [63:0] out_imm_b;
    logic [31:0] out_tag_b;
    logic [2:0]  out_fmt_b;
    logic [1:0]  cnt_b;

    imm_decode_stage #(.XLEN(32), .TAG_W(32), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_illegal(out_illegal_a),
        .out_tag(out_tag_a), .illegal_cnt(cnt_a));

    imm_decode_stage #(.XLEN(64), .TAG_W(32), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_illegal(out_illegal_b),
        .out_tag(out_tag_b), .illegal_cnt(cnt_b));

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tag;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   exp_cnt_a = 0;
    int   exp_cnt_b = 0;
    bit   acc_last;
    logic [63:0] cur_imm;
    logic [2:0]  cur_fmt;

    // Directed vectors: instruction, hand-computed 64-bit immediate, format.
    logic [31:0] v_inst[12] = '{32'hFFF00093, 32'h123452B7, 32'h800002B7, 32'hFE000EE3,
                                32'h0000007F, 32'hFE512C23, 32'h0080006F, 32'h00B50533,
                                32'h00001017, 32'h00412083, 32'h00000000, 32'hFFC08067};
    logic [63:0] v_imm[12]  = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000012345000,
                                64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC,
                                64'h0, 64'hFFFFFFFFFFFFFFF8, 64'h8, 64'h0,
                                64'h1000, 64'h4, 64'h0, 64'hFFFFFFFFFFFFFFFC};
    logic [2:0]  v_fmt[12]  = '{3'd1, 3'd4, 3'd4, 3'd3, 3'd7, 3'd2, 3'd5, 3'd0,
                                3'd4, 3'd1, 3'd7, 3'd1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        acc_last = in_valid && in_ready_a && !flush && !rst;
        if (acc_last) begin
            sb.push_back('{imm: cur_imm, fmt: cur_fmt, tag: in_tag});
            if (cur_fmt == 3'd7) begin
                exp_cnt_a++;
                if (exp_cnt_b < 3) exp_cnt_b++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [63:0] imm,
                         input logic [2:0] fmt, input logic [31:0] tag);
        in_valid = 1'b1;
        in_inst  = inst;
        in_tag   = tag;
        cur_imm  = imm;
        cur_fmt  = fmt;
    endtask

    task automatic send(input int idx, input logic [31:0] tag);
        offer(v_inst[idx], v_imm[idx], v_fmt[idx], tag);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (acc_last) break;
        end
        if (!acc_last) begin
            total++;
            $display("FAIL send_timeout: tag %h never accepted", tag);
        end
        in_valid = 1'b0;
        check("cnt_a", 64'(cnt_a), 64'(exp_cnt_a));
        check("cnt_b", 64'(cnt_b), 64'(exp_cnt_b));
    endtask

    // Monitor: pops one expected entry per consumed beat and checks stall stability.
    logic        stall_prev = 1'b0;
    logic [63:0] held_imm;
    logic [31:0] held_tag;
    logic [2:0]  held_fmt;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev && out_valid_a) begin
                check("stable_imm", out_imm_b, held_imm);
                check("stable_tag", 64'(out_tag_b), 64'(held_tag));
                check("stable_fmt", 64'(out_fmt_b), 64'(held_fmt));
            end
            if (out_valid_a && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_beat: got tag %h expected no beat", out_tag_a);
                end else begin
                    e = sb.pop_front();
                    check("valid_b", 64'(out_valid_b), 64'd1);
                    check("imm_a", 64'(out_imm_a), 64'(e.imm[31:0]));
                    check("imm_b", out_imm_b, e.imm);
                    check("fmt_a", 64'(out_fmt_a), 64'(e.fmt));
                    check("fmt_b", 64'(out_fmt_b), 64'(e.fmt));
                    check("illegal_a", 64'(out_illegal_a), 64'(e.fmt == 3'd7));
                    check("illegal_b", 64'(out_illegal_b), 64'(e.fmt == 3'd7));
                    check("tag_a", 64'(out_tag_a), 64'(e.tag));
                    check("tag_b", 64'(out_tag_b), 64'(e.tag));
                end
            end
            stall_prev = out_valid_a && !out_ready;
            held_imm   = out_imm_b;
            held_tag   = out_tag_b;
            held_fmt   = out_fmt_b;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = '0; in_tag = '0; cur_imm = '0; cur_fmt = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_a", 64'(out_valid_a), 64'd0);
        check("rst_valid_b", 64'(out_valid_b), 64'd0);
        check("rst_ready", 64'(in_ready_a), 64'd1);
        check("rst_fmt", 64'(out_fmt_a), 64'd7);
        check("rst_imm", out_imm_b, 64'd0);
        check("rst_illegal", 64'(out_illegal_a), 64'd0);
        check("rst_tag", 64'(out_tag_a), 64'd0);
        check("rst_cnt_a", 64'(cnt_a), 64'd0);
        check("rst_cnt_b", 64'(cnt_b), 64'd0);

        // Streaming with a ready consumer; first beat in the first post-reset cycle.
        rst = 1'b0;
        offer(v_inst[0], v_imm[0], v_fmt[0], 32'd100);
        tick();
        check("first_accept", 64'(acc_last), 64'd1);
        in_valid = 1'b0;
        for (int i = 1; i < 12; i++) send(i, 32'(100 + i));
        tick(); tick();
        check("stream_drained", 64'(out_valid_a), 64'd0);

        // Backpressure: tags 1,2 fill both entries, tag 3 waits.
        out_ready = 1'b0;
        send(0, 32'd1);
        send(3, 32'd2);
        check("bp_ready_low", 64'(in_ready_a), 64'd0);
        check("bp_ready_low_b", 64'(in_ready_b), 64'd0);
        check("bp_head_tag", 64'(out_tag_a), 64'd1);
        offer(v_inst[5], v_imm[5], v_fmt[5], 32'd3);
        tick();
        out_ready = 1'b1;
        check("bp_ready_still_low", 64'(in_ready_a), 64'd0);
        tick();
        check("bp_ready_back", 64'(in_ready_a), 64'd1);
        check("bp_valid_1", 64'(out_valid_a), 64'd1);
        check("bp_tag_2", 64'(out_tag_a), 64'd2);
        tick();
        check("bp_tag3_accepted", 64'(acc_last), 64'd1);
        in_valid = 1'b0;
        check("bp_valid_2", 64'(out_valid_a), 64'd1);
        check("bp_tag_3", 64'(out_tag_a), 64'd3);
        tick();
        check("bp_empty", 64'(out_valid_a), 64'd0);

        // Flush with both entries full and an illegal beat offered.
        out_ready = 1'b0;
        send(1, 32'h10);
        send(2, 32'h11);
        offer(v_inst[4], v_imm[4], v_fmt[4], 32'h12);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("flush_valid_a", 64'(out_valid_a), 64'd0);
        check("flush_valid_b", 64'(out_valid_b), 64'd0);
        check("flush_ready", 64'(in_ready_a), 64'd1);
        check("flush_cnt_a", 64'(cnt_a), 64'(exp_cnt_a));
        // Flush while empty and ready: the offered illegal beat must still drop.
        offer(v_inst[10], v_imm[10], v_fmt[10], 32'h13);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_drop_valid", 64'(out_valid_a), 64'd0);
        check("flush_drop_cnt_a", 64'(cnt_a), 64'(exp_cnt_a));
        check("flush_drop_cnt_b", 64'(cnt_b), 64'(exp_cnt_b));

        // Saturation of the 2-bit counter.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send((i % 2 == 0) ? 4 : 10, 32'(32'h20 + i));
        tick(); tick();
        check("sat_cnt_b", 64'(cnt_b), 64'd3);
        check("sat_cnt_a", 64'(cnt_a), 64'(exp_cnt_a));

        // Reset with both entries full.
        out_ready = 1'b0;
        send(6, 32'h30);
        send(7, 32'h31);
        rst = 1'b1;
        tick();
        sb.delete();
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        check("rst2_valid_a", 64'(out_valid_a), 64'd0);
        check("rst2_valid_b", 64'(out_valid_b), 64'd0);
        check("rst2_ready", 64'(in_ready_a), 64'd1);
        check("rst2_cnt_a", 64'(cnt_a), 64'd0);
        check("rst2_cnt_b", 64'(cnt_b), 64'd0);
        check("rst2_fmt", 64'(out_fmt_b), 64'd7);
        rst = 1'b0;
        out_ready = 1'b1;
        send(3, 32'h40);
        send(4, 32'h41);

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain: %0d beats outstanding, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
